qsys_serial_host_mm: RTL and testbench

Parametrised serial-to-Avalon-MM host bridge. Accepts a bit-serial command frame (read/write flag, address, write data), issues one Avalon-MM master transfer with full waitrequest and optional readdatavalid handling, then returns a status bit plus data serially. It sits between an external serial controller pin group and the Qsys interconnect, and exports the Qsys clock/reset conduit.

---
 rtl/qsys_serial_host_mm.sv | 219 +++++++++++++++++++++
 tb/tb_qsys_serial_host_mm.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/qsys_serial_host_mm.sv
// Serial-to-Avalon-MM host bridge: shifts in {rw, address, data}, runs one bus transfer, shifts out {status, data}.
// Optional bus-wait timeout is compiled in with `define SERIAL_HOST_TIMEOUT_EN.
module qsys_serial_host_mm #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 32,
    parameter int USE_RDV        = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sdi,
    input  logic                sle,
    output logic                sdo,
    output logic                srdy,
    output logic                rso_MRST_reset,
    output logic                cso_MCLK_clk,
    output logic [ADDR_W-1:0]   avm_M1_address,
    output logic [DATA_W-1:0]   avm_M1_writedata,
    input  logic [DATA_W-1:0]   avm_M1_readdata,
    output logic [DATA_W/8-1:0] avm_M1_byteenable,
    output logic                avm_M1_write,
    output logic                avm_M1_read,
    input  logic                avm_M1_readdatavalid,
    input  logic                avm_M1_waitrequest
);
    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam int RCNT_W  = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SHIFT, S_ISSUE, S_WAIT_REQ, S_WAIT_RDV, S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                is_wr_q, is_wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                read_q, read_d;
    logic                write_q, write_d;
    logic                srdy_q, srdy_d;
    logic                sdo_q, sdo_d;
    logic [DATA_W-1:0]   resp_q, resp_d;
    logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
    logic                load_resp;
    logic                load_status;
    logic [DATA_W-1:0]   load_data;

`ifdef SERIAL_HOST_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic                to_hit;
    assign to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0]         timeout_unused;
    assign timeout_unused = 32'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        cnt_d       = cnt_q;
        is_wr_d     = is_wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        read_d      = read_q;
        write_d     = write_q;
        srdy_d      = srdy_q;
        sdo_d       = sdo_q;
        resp_d      = resp_q;
        rcnt_d      = rcnt_q;
        load_resp   = 1'b0;
        load_status = 1'b0;
        load_data   = '0;
`ifdef SERIAL_HOST_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (sle) begin
                    frame_d = {frame_q[FRAME_W-2:0], sdi};
                    cnt_d   = CNT_W'(1);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (sle) begin
                    frame_d = {frame_q[FRAME_W-2:0], sdi};
                    if (cnt_q != CNT_W'(FRAME_W + 1))
                        cnt_d = cnt_q + CNT_W'(1);
                end else if (cnt_q == CNT_W'(FRAME_W)) begin
                    state_d = S_ISSUE;
                end else begin
                    // Wrong bit count: report an error without touching the bus.
                    load_resp   = 1'b1;
                    load_status = 1'b1;
                end
            end
            S_ISSUE: begin
                is_wr_d  = frame_q[FRAME_W-1];
                addr_d   = frame_q[FRAME_W-2 -: ADDR_W];
                wdata_d  = frame_q[DATA_W-1:0];
                write_d  = frame_q[FRAME_W-1];
                read_d   = ~frame_q[FRAME_W-1];
                state_d  = S_WAIT_REQ;
`ifdef SERIAL_HOST_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end
            S_WAIT_REQ: begin
                if (!avm_M1_waitrequest) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (is_wr_q) begin
                        load_resp = 1'b1;
                        load_data = wdata_q;
                    end else if (USE_RDV == 0) begin
                        load_resp = 1'b1;
                        load_data = avm_M1_readdata;
                    end else begin
                        state_d = S_WAIT_RDV;
                    end
                end
`ifdef SERIAL_HOST_TIMEOUT_EN
                else if (to_hit) begin
                    read_d      = 1'b0;
                    write_d     = 1'b0;
                    load_resp   = 1'b1;
                    load_status = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
`endif
            end
            S_WAIT_RDV: begin
                if (avm_M1_readdatavalid) begin
                    load_resp = 1'b1;
                    load_data = avm_M1_readdata;
                end
`ifdef SERIAL_HOST_TIMEOUT_EN
                else if (to_hit) begin
                    load_resp   = 1'b1;
                    load_status = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
`endif
            end
            S_RESP: begin
                // Status bit is already on sdo; rcnt counts data bits still to send.
                if (rcnt_q != '0) begin
                    sdo_d  = resp_q[DATA_W-1];
                    resp_d = {resp_q[DATA_W-2:0], 1'b0};
                    rcnt_d = rcnt_q - RCNT_W'(1);
                end else begin
                    srdy_d  = 1'b0;
                    sdo_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load_resp) begin
            state_d = S_RESP;
            srdy_d  = 1'b1;
            sdo_d   = load_status;
            resp_d  = load_data;
            rcnt_d  = RCNT_W'(DATA_W);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            frame_q  <= '0;
            cnt_q    <= '0;
            is_wr_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            srdy_q   <= 1'b0;
            sdo_q    <= 1'b0;
            resp_q   <= '0;
            rcnt_q   <= '0;
`ifdef SERIAL_HOST_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            cnt_q    <= cnt_d;
            is_wr_q  <= is_wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            read_q   <= read_d;
            write_q  <= write_d;
            srdy_q   <= srdy_d;
            sdo_q    <= sdo_d;
            resp_q   <= resp_d;
            rcnt_q   <= rcnt_d;
`ifdef SERIAL_HOST_TIMEOUT_EN
            to_cnt_q <= to_cnt_d;
`endif
        end
    end

    assign sdo               = sdo_q;
    assign srdy              = srdy_q;
    assign rso_MRST_reset    = reset;
    assign cso_MCLK_clk      = clk;
    assign avm_M1_address    = addr_q;
    assign avm_M1_writedata  = wdata_q;
    assign avm_M1_byteenable = '1;
    assign avm_M1_write      = write_q;
    assign avm_M1_read       = read_q;
endmodule

// File: tb/tb_qsys_serial_host_mm.sv
// Directed + randomized bench for qsys_serial_host_mm with a behavioural frame/response model and Avalon slave.
module tb_qsys_serial_host_mm;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 16;
    localparam int FW = 1 + AW + DW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            sdi = 1'b0;
    logic            sle = 1'b0;
    logic            sdo, srdy, mrst, mclk;
    logic [AW-1:0]   address;
    logic [DW-1:0]   writedata;
    logic [DW-1:0]   readdata = '0;
    logic [DW/8-1:0] be;
    logic            wr, rd;
    logic            rdv = 1'b0;
    logic            waitreq = 1'b1;

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] model_mem [256];
    logic [DW-1:0] slave_mem [256];

    always #5 clk = ~clk;

    qsys_serial_host_mm #(
        .ADDR_W(AW), .DATA_W(DW), .USE_RDV(1), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(rst), .sdi(sdi), .sle(sle), .sdo(sdo), .srdy(srdy),
        .rso_MRST_reset(mrst), .cso_MCLK_clk(mclk),
        .avm_M1_address(address), .avm_M1_writedata(writedata),
        .avm_M1_readdata(readdata), .avm_M1_byteenable(be),
        .avm_M1_write(wr), .avm_M1_read(rd),
        .avm_M1_readdatavalid(rdv), .avm_M1_waitrequest(waitreq)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [FW-1:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            sle = 1'b1;
            sdi = (i < FW) ? frame[FW-1-i] : 1'($urandom);
            @(posedge clk); #1;
        end
        sle = 1'b0;
        sdi = 1'b0;
    endtask

    // One complete command/response exchange; the model predicts strobe count, latency and response word.
    task automatic txn(input string tag, input bit is_wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input int nbits, input int waits,
                       input int rdv_dly, input int sle_poke);
        bit            frame_ok = (nbits == FW);
        bit            timed_out = 1'b0;
        logic [DW:0]   exp_resp, obs_resp;
        int            exp_strobes, exp_lat;
        int            nstrobe = 0, nsrdy = 0, lat = -1, after = 0;
        bit            accepted = 1'b0, bus_bad = 1'b0, done = 1'b0;
        logic [AW-1:0] slave_addr = '0;
        obs_resp = '0;
`ifdef SERIAL_HOST_TIMEOUT_EN
        timed_out = frame_ok && (waits >= TO);
`endif
        if (!frame_ok) begin
            exp_resp = {1'b1, {DW{1'b0}}}; exp_strobes = 0; exp_lat = 1;
        end else if (timed_out) begin
            exp_resp = {1'b1, {DW{1'b0}}}; exp_strobes = TO; exp_lat = 2 + TO;
        end else if (is_wr) begin
            exp_resp = {1'b0, d}; exp_strobes = waits + 1; exp_lat = 3 + waits;
            model_mem[a] = d;
        end else begin
            exp_resp = {1'b0, model_mem[a]}; exp_strobes = waits + 1; exp_lat = 3 + waits + rdv_dly;
        end

        send_frame({is_wr, a, d}, nbits);
        for (int k = 1; k <= 600 && !done; k++) begin
            @(posedge clk); #1;
            if (rd || wr) begin
                nstrobe++;
                if (address !== a || (rd && wr) || wr !== is_wr || (is_wr && writedata !== d))
                    bus_bad = 1'b1;
                waitreq = (nstrobe <= waits);
                rdv = (!is_wr && waitreq);
                readdata = 32'hBAD0_0000 | DW'(nstrobe);
                if (!waitreq) begin
                    accepted = 1'b1;
                    slave_addr = address;
                    if (is_wr) slave_mem[address] = writedata;
                end
            end else begin
                waitreq = 1'b1;
                rdv = 1'b0;
                readdata = $urandom;
                if (accepted && !is_wr) begin
                    after++;
                    if (after == rdv_dly) begin
                        rdv = 1'b1;
                        readdata = slave_mem[slave_addr];
                    end
                end
            end
            if (srdy) begin
                if (nsrdy == 0) lat = k;
                if (nsrdy <= DW) obs_resp[DW-nsrdy] = sdo;
                nsrdy++;
                if (sle_poke > 0 && nsrdy >= sle_poke && nsrdy < sle_poke + 5) begin
                    sle = 1'b1;
                    sdi = 1'($urandom);
                end else begin
                    sle = 1'b0;
                end
            end else if (nsrdy > 0) begin
                done = 1'b1;
            end
        end
        waitreq = 1'b1;
        rdv = 1'b0;
        sle = 1'b0;
        chk($sformatf("%s done", tag), 64'(done), 64'd1);
        chk($sformatf("%s strobes", tag), 64'(nstrobe), 64'(exp_strobes));
        chk($sformatf("%s bus", tag), 64'(bus_bad), 64'd0);
        chk($sformatf("%s srdy_len", tag), 64'(nsrdy), 64'(DW + 1));
        chk($sformatf("%s latency", tag), 64'(lat), 64'(exp_lat));
        chk($sformatf("%s resp", tag), 64'(obs_resp), 64'(exp_resp));
        $display("[TB] txn %s wr=%0d addr=%0h nbits=%0d waits=%0d resp=%0h", tag, is_wr, a, nbits, waits, obs_resp);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] v;
        int nb;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            model_mem[i] = v;
            slave_mem[i] = v;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst sdo", 64'(sdo), 64'd0);
        chk("rst srdy", 64'(srdy), 64'd0);
        chk("rst read", 64'(rd), 64'd0);
        chk("rst write", 64'(wr), 64'd0);
        chk("rst address", 64'(address), 64'd0);
        chk("rst writedata", 64'(writedata), 64'd0);
        chk("byteenable", 64'(be), 64'hF);
        chk("reset conduit hi", 64'(mrst), 64'd1);
        rst = 1'b0;
        #1;
        chk("reset conduit lo", 64'(mrst), 64'd0);
        chk("clk conduit", 64'(mclk), 64'(clk));
        @(posedge clk); #1;

        txn("write_12", 1'b1, 8'h12, 32'hDEADBEEF, FW, 0, 1, 0);
        model_mem[8'h34] = 32'hCAFEF00D;
        slave_mem[8'h34] = 32'hCAFEF00D;
        txn("read_34", 1'b0, 8'h34, 32'h0, FW, 5, 2, 0);
        txn("short40", 1'b1, 8'h55, 32'h12345678, 40, 0, 1, 0);
        txn("long42", 1'b1, 8'h56, 32'h87654321, FW + 1, 0, 1, 0);
        txn("long60", 1'b0, 8'h57, 32'h0, 60, 0, 1, 0);
        txn("stall40", 1'b0, 8'h12, 32'h0, FW, 40, 1, 0);
        txn("b2b_first", 1'b1, 8'h20, 32'h0BAD_CAFE, FW, 0, 1, 5);
        txn("b2b_second", 1'b1, 8'h21, 32'h1357_9BDF, FW, 1, 1, 0);
        txn("readback_20", 1'b0, 8'h20, 32'h0, FW, 0, 1, 0);

        // Reset while the read strobe is being stalled.
        send_frame({1'b0, 8'h66, 32'h0}, FW);
        repeat (4) @(posedge clk);
        #1;
        chk("pre-reset read", 64'(rd), 64'd1);
        rst = 1'b1;
        #1;
        chk("async reset read", 64'(rd), 64'd0);
        chk("async reset srdy", 64'(srdy), 64'd0);
        chk("async reset address", 64'(address), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        txn("post_reset_wr", 1'b1, 8'h66, 32'hA5A5_5A5A, FW, 2, 1, 0);
        txn("post_reset_rd", 1'b0, 8'h66, 32'h0, FW, 1, 3, 0);

        for (int t = 0; t < 20; t++) begin
            nb = FW;
            if ($urandom_range(0, 5) == 0) nb = (($urandom & 1) != 0) ? FW + 1 + $urandom_range(0, 8) : $urandom_range(2, FW - 1);
            txn($sformatf("rand%0d", t), 1'($urandom), 8'($urandom), $urandom, nb,
                $urandom_range(0, 4), $urandom_range(1, 3), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
